// File: rtl/vga_scan_gen_pkg.sv
// Shared 640x480@60 raster constants and sync polarity used by the scan
// generator and the flag renderers.
package vga_scan_gen_pkg;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Level driven on hsync/vsync during the sync pulse.
    localparam logic SYNC_ACTIVE = 1'b0;

    // Inclusive range test on a 10-bit scan coordinate.
    function automatic logic in_range(input logic [9:0] v,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_gen_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a
// single-cycle rising-edge detect.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_o = r_sync & ~r_prev;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster timing generator: scan counters, registered sync/enable decode,
// pad-side delay pipe, frame counter and flag-selection sequencer.
module vga_scan_gen
    import vga_scan_gen_pkg::*;
#(
    parameter int H_VIS       = DEF_H_VIS,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_VIS       = DEF_V_VIS,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int PIPE        = 1,
    parameter int NUM_FLAGS   = 8,
    parameter int HOLD_FRAMES = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_i,
    input  logic       pause_i,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic       frame_tick,
    output logic [7:0] frame_cnt,
    output logic [3:0] flag_sel
);

    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] H_SS    = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SE    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SS    = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SE    = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [3:0] FLAG_LAST = 4'(NUM_FLAGS - 1);
    localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);

    logic [9:0]      r_x, r_y;
    logic            r_hsync, r_vsync, r_de, r_tick;
    logic [PIPE-1:0] r_hs_pipe, r_vs_pipe, r_de_pipe;
    logic [7:0]      r_frame_cnt;
    logic [3:0]      r_flag;
    logic [9:0]      r_hold;
    logic            r_adv_pending;

    logic [9:0] w_x_next, w_y_next;
    logic       w_x_wrap, w_frame_wrap;
    logic       w_rise, w_adv;

    btn_sync_edge u_btn (
        .clk    (clk),
        .reset  (reset),
        .d_i    (btn_i),
        .rise_o (w_rise)
    );

    // Next scan position; the sync decode uses it so outputs line up with pix_x/pix_y.
    always_comb begin
        w_x_wrap     = (r_x == H_LAST);
        w_frame_wrap = w_x_wrap && (r_y == V_LAST);
        w_x_next     = w_x_wrap ? 10'd0 : r_x + 10'd1;
        w_y_next     = r_y;
        if (w_x_wrap)
            w_y_next = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        w_adv = r_adv_pending | w_rise | (!pause_i && (r_hold == HOLD_LAST));
    end

    // Scan counters, sync/enable decode and the wrap-driven frame tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
            r_de    <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_hsync <= in_range(w_x_next, H_SS, H_SE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= in_range(w_y_next, V_SS, V_SE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_de    <= (w_x_next < H_VIS_L) && (w_y_next < V_VIS_L);
            r_tick  <= w_frame_wrap;
        end
    end

    // Delay line matching the registered colour path; flushed to idle levels on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_pipe <= '1;
            r_vs_pipe <= '1;
            r_de_pipe <= '0;
        end else begin
            r_hs_pipe <= PIPE'({r_hs_pipe, r_hsync});
            r_vs_pipe <= PIPE'({r_vs_pipe, r_vsync});
            r_de_pipe <= PIPE'({r_de_pipe, r_de});
        end
    end

    // Frame count and flag rotation; everything changes only on the tick so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt   <= 8'd0;
            r_flag        <= 4'd0;
            r_hold        <= 10'd0;
            r_adv_pending <= 1'b0;
        end else if (r_tick) begin
            r_frame_cnt   <= r_frame_cnt + 8'd1;
            r_adv_pending <= 1'b0;
            if (w_adv) begin
                r_flag <= (r_flag == FLAG_LAST) ? 4'd0 : r_flag + 4'd1;
                r_hold <= 10'd0;
            end else if (!pause_i) begin
                r_hold <= r_hold + 10'd1;
            end
        end else if (w_rise) begin
            r_adv_pending <= 1'b1;
        end
    end

    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign display_on = r_de;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign hsync_o    = r_hs_pipe[PIPE-1];
    assign vsync_o    = r_vs_pipe[PIPE-1];
    assign de_o       = r_de_pipe[PIPE-1];
    assign frame_tick = r_tick;
    assign frame_cnt  = r_frame_cnt;
    assign flag_sel   = r_flag;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: full 640x480 instance (PIPE=2) for horizontal timing and the
// delay pipe; a shrunken-raster instance (16x10 total, HOLD=2, 3 flags) for
// vertical timing, frame tick and the flag sequencer within a short run.
module tb_vga_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       rst_h = 1'b1, btn_h = 1'b0, pause_h = 1'b1;
    logic [9:0] h_x, h_y;
    logic       h_de, h_hs, h_vs, h_hs_o, h_vs_o, h_de_o, h_tick;
    logic [7:0] h_cnt;
    logic [3:0] h_flag;

    logic       rst_s = 1'b1, btn_s = 1'b0, pause_s = 1'b1;
    logic [9:0] s_x, s_y;
    logic       s_de, s_hs, s_vs, s_hs_o, s_vs_o, s_de_o, s_tick;
    logic [7:0] s_cnt;
    logic [3:0] s_flag;

    vga_scan_gen #(.PIPE(2)) dut_h (
        .clk(clk), .reset(rst_h), .btn_i(btn_h), .pause_i(pause_h),
        .pix_x(h_x), .pix_y(h_y), .display_on(h_de), .hsync(h_hs), .vsync(h_vs),
        .hsync_o(h_hs_o), .vsync_o(h_vs_o), .de_o(h_de_o),
        .frame_tick(h_tick), .frame_cnt(h_cnt), .flag_sel(h_flag)
    );

    vga_scan_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE(1), .NUM_FLAGS(3), .HOLD_FRAMES(2)
    ) dut_s (
        .clk(clk), .reset(rst_s), .btn_i(btn_s), .pause_i(pause_s),
        .pix_x(s_x), .pix_y(s_y), .display_on(s_de), .hsync(s_hs), .vsync(s_vs),
        .hsync_o(s_hs_o), .vsync_o(s_vs_o), .de_o(s_de_o),
        .frame_tick(s_tick), .frame_cnt(s_cnt), .flag_sel(s_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_s();
        rst_s = 1'b1;
        step(2);
        rst_s = 1'b0;
    endtask

    task automatic wait_tick_s(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step(1);
            if (s_tick) ok = 1'b1;
        end
        check(tag, ok, 1);
    endtask

    task automatic check_reset_s(input string tag);
        check({tag, "_x"}, s_x, 0);
        check({tag, "_y"}, s_y, 0);
        check({tag, "_de"}, s_de, 1);
        check({tag, "_hs"}, s_hs, 1);
        check({tag, "_vs"}, s_vs, 1);
        check({tag, "_hs_o"}, s_hs_o, 1);
        check({tag, "_vs_o"}, s_vs_o, 1);
        check({tag, "_de_o"}, s_de_o, 0);
        check({tag, "_tick"}, s_tick, 0);
        check({tag, "_cnt"}, s_cnt, 0);
        check({tag, "_flag"}, s_flag, 0);
    endtask

    function automatic bit hs_full(input int x);
        return !(x >= 656 && x <= 751);
    endfunction

    int exp4 [7] = '{0, 1, 1, 2, 2, 0, 0};

    initial begin
        int lowcnt;
        int prev;
        int x, y;

        // ---------------- Test 1/3: full-size horizontal line, PIPE=2 ----------------
        step(2);
        rst_h = 1'b0;
        check("h_rst_x", h_x, 0);
        check("h_rst_y", h_y, 0);
        check("h_rst_tick", h_tick, 0);
        check("h_rst_cnt", h_cnt, 0);
        check("h_rst_flag", h_flag, 0);
        check("h_rst_vs", h_vs, 1);
        lowcnt = 0;
        for (int n = 0; n < 800; n++) begin
            check("t1_pix_x", h_x, n);
            check("t1_pix_y", h_y, 0);
            check("t1_hsync", h_hs, hs_full(n));
            check("t1_display_on", h_de, n < 640);
            if (n < 2) begin
                check("t3_hs_o_flush", h_hs_o, 1);
                check("t3_vs_o_flush", h_vs_o, 1);
                check("t3_de_o_flush", h_de_o, 0);
            end else begin
                check("t3_hs_o", h_hs_o, hs_full(n - 2));
                check("t3_vs_o", h_vs_o, 1);
                check("t3_de_o", h_de_o, (n - 2) < 640);
            end
            if (h_hs === 1'b0) lowcnt++;
            step(1);
        end
        check("t1_hsync_low_cycles", lowcnt, 96);
        check("t1_y_step", h_y, 1);
        check("t1_x_wrap", h_x, 0);

        // ---------------- Test 2: vertical timing and frame tick (small raster) -------
        pause_s = 1'b1;
        reset_s();
        check_reset_s("t2_rst");
        lowcnt = 0;
        for (int n = 0; n < 160; n++) begin
            x = n % 16;
            y = n / 16;
            check("t2_pix_x", s_x, x);
            check("t2_pix_y", s_y, y);
            check("t2_vsync", s_vs, !(y == 7 || y == 8));
            check("t2_hsync", s_hs, !(x >= 10 && x <= 13));
            check("t2_display_on", s_de, (x < 8) && (y < 6));
            check("t2_no_tick", s_tick, 0);
            if (n >= 1)
                check("t2_de_o", s_de_o, (((n - 1) % 16) < 8) && (((n - 1) / 16) < 6));
            if (s_vs === 1'b0) lowcnt++;
            step(1);
        end
        check("t2_vsync_low_cycles", lowcnt, 32);
        check("t2_tick", s_tick, 1);
        check("t2_tick_x", s_x, 0);
        check("t2_tick_y", s_y, 0);
        check("t2_cnt_at_tick", s_cnt, 0);
        step(1);
        check("t2_tick_pulse", s_tick, 0);
        check("t2_cnt_after", s_cnt, 1);

        // ---------------- Test 4: auto rotation, HOLD=2, 3 flags ---------------------
        pause_s = 1'b0;
        reset_s();
        prev = 0;
        for (int k = 0; k < 7; k++) begin
            wait_tick_s("t4_tick_seen");
            check("t4_flag_at_tick", s_flag, prev);
            step(1);
            check("t4_flag_after_tick", s_flag, exp4[k]);
            prev = exp4[k];
        end

        // ---------------- Test 5: paused, three button pulses -> one advance ----------
        pause_s = 1'b1;
        reset_s();
        step(2);
        for (int p = 0; p < 3; p++) begin
            btn_s = 1'b1;
            step(5);
            btn_s = 1'b0;
            step(5);
        end
        check("t5_flag_before_tick", s_flag, 0);
        wait_tick_s("t5_tick_seen");
        check("t5_flag_at_tick", s_flag, 0);
        step(1);
        check("t5_flag_advanced", s_flag, 1);
        for (int k = 0; k < 2; k++) begin
            wait_tick_s("t5_tick_seen_paused");
            step(1);
            check("t5_flag_held", s_flag, 1);
        end

        // ---------------- Test 6: mid-frame reset drops a pending advance ------------
        pause_s = 1'b1;
        reset_s();
        wait_tick_s("t6_tick_seen");
        step(5);
        btn_s = 1'b1;
        step(5);
        btn_s = 1'b0;
        step(20);
        check("t6_pending_set", dut_s.r_adv_pending, 1);
        check("t6_cnt_pre", s_cnt, 1);
        check("t6_x_pre_nonzero", (s_x != 10'd0), 1);
        rst_s = 1'b1;
        step(1);
        rst_s = 1'b0;
        check_reset_s("t6_rst");
        wait_tick_s("t6_tick_after_rst");
        step(1);
        check("t6_flag_no_advance", s_flag, 0);
        check("t6_cnt_after", s_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
